// File: rtl/ram_cmd_master.sv
// Purpose: initiator for the single-port RAM command bus; turns read/write requests into two-beat din sequences and returns one response per request.
// Latency: counted from the handshake cycle, rsp_valid arrives 3 cycles later for writes and 4 for reads answered one cycle after the 11 beat.
// Backpressure: req_ready is high only while idle; responses are single-cycle pulses and the consumer cannot stall them.
module ram_cmd_master #(
    parameter int ADDR_SIZE = 8,
    parameter int TIMEOUT   = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_write,
    input  logic [ADDR_SIZE-1:0] req_addr,
    input  logic [ADDR_SIZE-1:0] req_wdata,
    output logic [ADDR_SIZE+1:0] din,
    output logic                 rx_valid,
    input  logic [ADDR_SIZE-1:0] dout,
    input  logic                 tx_valid,
    output logic                 rsp_valid,
    output logic                 rsp_write,
    output logic [ADDR_SIZE-1:0] rsp_data,
    output logic                 rsp_err,
    output logic                 proto_err
);

    // Counter wide enough to hold 0 .. TIMEOUT-1.
    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    localparam logic [1:0] OP_WA = 2'b00;
    localparam logic [1:0] OP_WD = 2'b01;
    localparam logic [1:0] OP_RA = 2'b10;
    localparam logic [1:0] OP_RD = 2'b11;

    localparam logic [ADDR_SIZE-1:0] ZERO = '0;

    // Each state names the beat currently on din (WAIT_TX: none, 11 held).
    typedef enum logic [2:0] {
        IDLE,
        WR_ADDR,
        WR_DATA,
        RD_ADDR,
        RD_DATA,
        WAIT_TX
    } state_t;

    state_t                 state;
    state_t                 state_nx;
    logic [CW-1:0]          cnt;
    logic [CW-1:0]          cnt_nx;
    logic [ADDR_SIZE-1:0]   wdata_q;
    logic [ADDR_SIZE-1:0]   wdata_nx;

    logic                   req_ready_nx;
    logic [ADDR_SIZE+1:0]   din_nx;
    logic                   rx_valid_nx;
    logic                   rsp_valid_nx;
    logic                   rsp_write_nx;
    logic [ADDR_SIZE-1:0]   rsp_data_nx;
    logic                   rsp_err_nx;
    logic                   proto_err_nx;

    // State, counter, captured write data and every output are registered here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            wdata_q   <= '0;
            req_ready <= 1'b1;
            din       <= {OP_WD, ZERO};
            rx_valid  <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_write <= 1'b0;
            rsp_data  <= '0;
            rsp_err   <= 1'b0;
            proto_err <= 1'b0;
        end else begin
            state     <= state_nx;
            cnt       <= cnt_nx;
            wdata_q   <= wdata_nx;
            req_ready <= req_ready_nx;
            din       <= din_nx;
            rx_valid  <= rx_valid_nx;
            rsp_valid <= rsp_valid_nx;
            rsp_write <= rsp_write_nx;
            rsp_data  <= rsp_data_nx;
            rsp_err   <= rsp_err_nx;
            proto_err <= proto_err_nx;
        end
    end

    // Next state and next output values; the beat for a state is launched on the edge that enters it.
    always_comb begin
        state_nx     = state;
        cnt_nx       = cnt;
        wdata_nx     = wdata_q;
        din_nx       = din;
        rx_valid_nx  = 1'b0;
        rsp_valid_nx = 1'b0;
        rsp_write_nx = 1'b0;
        rsp_data_nx  = '0;
        rsp_err_nx   = 1'b0;
        // A reply outside the wait window means the RAM and master disagree; latch it.
        proto_err_nx = proto_err | (tx_valid && (state != WAIT_TX));

        case (state)
            IDLE: begin
                if (req_valid && req_ready) begin
                    wdata_nx    = req_wdata;
                    rx_valid_nx = 1'b1;
                    if (req_write) begin
                        state_nx = WR_ADDR;
                        din_nx   = {OP_WA, req_addr};
                    end else begin
                        state_nx = RD_ADDR;
                        din_nx   = {OP_RA, req_addr};
                    end
                end
            end
            WR_ADDR: begin
                state_nx    = WR_DATA;
                din_nx      = {OP_WD, wdata_q};
                rx_valid_nx = 1'b1;
            end
            WR_DATA: begin
                state_nx     = IDLE;
                rsp_valid_nx = 1'b1;
                rsp_write_nx = 1'b1;
            end
            RD_ADDR: begin
                state_nx    = RD_DATA;
                din_nx      = {OP_RD, ZERO};
                rx_valid_nx = 1'b1;
            end
            RD_DATA: begin
                state_nx = WAIT_TX;
                cnt_nx   = '0;
            end
            WAIT_TX: begin
                // Data arriving on the final wait cycle still beats the timeout.
                if (tx_valid) begin
                    state_nx     = IDLE;
                    rsp_valid_nx = 1'b1;
                    rsp_data_nx  = dout;
                end else if (cnt == CNT_LAST) begin
                    state_nx     = IDLE;
                    rsp_valid_nx = 1'b1;
                    rsp_err_nx   = 1'b1;
                end else begin
                    cnt_nx = cnt + CW'(1);
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase

        // Ready rises together with the response pulse so the next request sees no gap.
        req_ready_nx = (state_nx == IDLE);
    end

endmodule

// File: tb/tb_ram_cmd_master.sv
module tb_ram_cmd_master;

    localparam int AW = 8;
    localparam int TO = 4;

    logic          clk;
    logic          rst_n;
    logic          req_valid;
    logic          req_ready;
    logic          req_write;
    logic [AW-1:0] req_addr;
    logic [AW-1:0] req_wdata;
    logic [AW+1:0] din;
    logic          rx_valid;
    logic [AW-1:0] dout = '0;
    logic          tx_valid = 1'b0;
    logic          rsp_valid;
    logic          rsp_write;
    logic [AW-1:0] rsp_data;
    logic          rsp_err;
    logic          proto_err;

    int n_chk = 0;
    int n_err = 0;

    ram_cmd_master #(.ADDR_SIZE(AW), .TIMEOUT(TO)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .din       (din),
        .rx_valid  (rx_valid),
        .dout      (dout),
        .tx_valid  (tx_valid),
        .rsp_valid (rsp_valid),
        .rsp_write (rsp_write),
        .rsp_data  (rsp_data),
        .rsp_err   (rsp_err),
        .proto_err (proto_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // RAM peer: decodes din beats, answers a read ram_delay cycles after the 11 beat (0 = never).
    int         ram_delay = 1;
    int         pend = 0;
    int         spur_req = 0;
    int         spur_ack = 0;
    logic [7:0] ram_mem [256];
    logic [7:0] ra = '0;

    always begin
        @(posedge clk);
        #1;
        tx_valid = 1'b0;
        dout     = 8'($urandom);
        if (pend > 0) begin
            pend--;
            if (pend == 0) begin
                tx_valid = 1'b1;
                dout     = ram_mem[ra];
            end
        end
        if (spur_req != spur_ack) begin
            tx_valid = 1'b1;
            spur_ack = spur_req;
        end
        @(negedge clk);
        if (!rst_n) begin
            pend = 0;
            for (int i = 0; i < 256; i++) ram_mem[i] = '0;
        end else if (rx_valid) begin
            case (din[9:8])
                2'b00: ra = din[7:0];
                2'b01: ram_mem[ra] = din[7:0];
                2'b10: ra = din[7:0];
                default: pend = ram_delay;
            endcase
        end
    end

    // One request from handshake to response; latency counted in cycles after the handshake cycle.
    task automatic do_req(input bit w, input logic [7:0] a, input logic [7:0] wd,
                          output int lat, output logic [9:0] b1, output logic [9:0] b2,
                          output logic rw, output logic [7:0] rd, output logic re, output logic rr);
        int k;
        lat = -1; b1 = 10'h3FF; b2 = 10'h3FF; rw = 1'bx; rd = 8'hxx; re = 1'bx; rr = 1'bx;
        k = 0;
        @(negedge clk);
        while (!req_ready && k < 20) begin
            @(negedge clk);
            k++;
        end
        if (!req_ready) chk("req_ready_wait", 32'(req_ready), 1);
        req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = wd;
        @(posedge clk);
        #1 req_valid = 1'b0; req_addr = 8'($urandom); req_wdata = 8'($urandom);
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (i == 1 && rx_valid) b1 = din;
            if (i == 2 && rx_valid) b2 = din;
            if (rsp_valid) begin
                lat = i; rw = rsp_write; rd = rsp_data; re = rsp_err; rr = req_ready;
                break;
            end
        end
    endtask

    typedef struct {
        bit         w;
        logic [7:0] a;
        logic [7:0] wd;
        int         d;
        logic [9:0] b1;
        logic [9:0] b2;
        int         lat;
        logic       rw;
        logic [7:0] rd;
        logic       re;
    } vec_t;

    function automatic vec_t mk(bit w, logic [7:0] a, logic [7:0] wd, int d, logic [9:0] b1,
                                logic [9:0] b2, int lat, logic rw, logic [7:0] rd, logic re);
        vec_t v;
        v.w = w; v.a = a; v.wd = wd; v.d = d; v.b1 = b1; v.b2 = b2;
        v.lat = lat; v.rw = rw; v.rd = rd; v.re = re;
        return v;
    endfunction

    typedef struct packed {
        logic       w;
        logic [7:0] d;
        logic       e;
    } rsp_t;

    logic [9:0] exp_din [int];
    rsp_t       exp_rsp [int];
    logic [7:0] mem_m [256];

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t       vt [9];
        int         lat;
        logic [9:0] b1, b2;
        logic       rw, re, rr;
        logic [7:0] rd;
        bit         seen;
        int         cyc, free_at, proto_from, d;
        bit         rdy_m;
        logic [9:0] last_din;

        rst_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;

        // Reset values while held in reset.
        #12;
        chk("rst_req_ready", 32'(req_ready), 1);
        chk("rst_rx_valid", 32'(rx_valid), 0);
        chk("rst_din", 32'(din), 32'h100);
        chk("rst_rsp_valid", 32'(rsp_valid), 0);
        chk("rst_rsp_fields", {rsp_write, rsp_data, rsp_err}, 0);
        chk("rst_proto_err", 32'(proto_err), 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed vectors: expected beats, latency and response derived by hand (TIMEOUT=4).
        vt[0] = mk(1'b1, 8'h3C, 8'hA5, 1, 10'h03C, 10'h1A5, 3, 1'b1, 8'h00, 1'b0);
        vt[1] = mk(1'b0, 8'h3C, 8'h00, 1, 10'h23C, 10'h300, 4, 1'b0, 8'hA5, 1'b0);
        vt[2] = mk(1'b0, 8'h3C, 8'h00, 0, 10'h23C, 10'h300, 7, 1'b0, 8'h00, 1'b1);
        vt[3] = mk(1'b0, 8'h3C, 8'h00, 4, 10'h23C, 10'h300, 7, 1'b0, 8'hA5, 1'b0);
        vt[4] = mk(1'b1, 8'h01, 8'h5A, 1, 10'h001, 10'h15A, 3, 1'b1, 8'h00, 1'b0);
        vt[5] = mk(1'b0, 8'h01, 8'h00, 2, 10'h201, 10'h300, 5, 1'b0, 8'h5A, 1'b0);
        vt[6] = mk(1'b0, 8'h77, 8'h00, 3, 10'h277, 10'h300, 6, 1'b0, 8'h00, 1'b0);
        vt[7] = mk(1'b1, 8'hFF, 8'hFF, 1, 10'h0FF, 10'h1FF, 3, 1'b1, 8'h00, 1'b0);
        vt[8] = mk(1'b0, 8'hFF, 8'h00, 1, 10'h2FF, 10'h300, 4, 1'b0, 8'hFF, 1'b0);

        for (int i = 0; i < 9; i++) begin
            ram_delay = vt[i].d;
            do_req(vt[i].w, vt[i].a, vt[i].wd, lat, b1, b2, rw, rd, re, rr);
            chk($sformatf("v%0d_beat1", i), 32'(b1), 32'(vt[i].b1));
            chk($sformatf("v%0d_beat2", i), 32'(b2), 32'(vt[i].b2));
            chk($sformatf("v%0d_latency", i), 32'(lat), 32'(vt[i].lat));
            chk($sformatf("v%0d_rsp_write", i), 32'(rw), 32'(vt[i].rw));
            chk($sformatf("v%0d_rsp_data", i), 32'(rd), 32'(vt[i].rd));
            chk($sformatf("v%0d_rsp_err", i), 32'(re), 32'(vt[i].re));
            chk($sformatf("v%0d_ready_at_rsp", i), 32'(rr), 1);
        end

        // Back-to-back: write then read with req_valid held high throughout.
        ram_delay = 1;
        @(negedge clk);
        chk("b2b_ready0", 32'(req_ready), 1);
        req_valid = 1'b1; req_write = 1'b1; req_addr = 8'h10; req_wdata = 8'hC3;
        @(posedge clk);
        #1 req_write = 1'b0; req_addr = 8'h10;
        @(negedge clk);
        chk("b2b_wa_beat", {rx_valid, din}, {1'b1, 10'h010});
        chk("b2b_not_ready", 32'(req_ready), 0);
        @(negedge clk);
        chk("b2b_wd_beat", {rx_valid, din}, {1'b1, 10'h1C3});
        @(negedge clk);
        chk("b2b_wr_rsp", {rsp_valid, rsp_write, rsp_err}, 3'b110);
        chk("b2b_ready_with_rsp", 32'(req_ready), 1);
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        chk("b2b_ra_beat", {rx_valid, din}, {1'b1, 10'h210});
        @(negedge clk);
        chk("b2b_rd_beat", {rx_valid, din}, {1'b1, 10'h300});
        @(negedge clk);
        chk("b2b_wait_hold", {rx_valid, din, rsp_valid}, {1'b0, 10'h300, 1'b0});
        @(negedge clk);
        chk("b2b_rd_rsp", {rsp_valid, rsp_write, rsp_data, rsp_err}, {1'b1, 1'b0, 8'hC3, 1'b0});

        // Spurious tx_valid while idle makes proto_err sticky until reset.
        @(negedge clk);
        spur_req++;
        @(negedge clk);
        chk("spur_not_yet", 32'(proto_err), 0);
        @(negedge clk);
        chk("spur_set", 32'(proto_err), 1);
        ram_delay = 1;
        do_req(1'b1, 8'h20, 8'h11, lat, b1, b2, rw, rd, re, rr);
        chk("spur_wr_lat", 32'(lat), 3);
        chk("spur_sticky1", 32'(proto_err), 1);
        do_req(1'b0, 8'h20, 8'h00, lat, b1, b2, rw, rd, re, rr);
        chk("spur_rd_data", 32'(rd), 32'h11);
        chk("spur_sticky2", 32'(proto_err), 1);
        @(negedge clk);
        rst_n = 1'b0;
        #1 chk("spur_cleared_by_rst", 32'(proto_err), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Reset asserted in the RD_DATA cycle abandons the read.
        @(negedge clk);
        chk("mid_ready", 32'(req_ready), 1);
        ram_delay = 1;
        req_valid = 1'b1; req_write = 1'b0; req_addr = 8'h3C;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        chk("mid_ra_beat", {rx_valid, din}, {1'b1, 10'h23C});
        @(posedge clk);
        #2 chk("mid_rd_beat", {rx_valid, din}, {1'b1, 10'h300});
        rst_n = 1'b0;
        #1 chk("mid_rst_rx_valid", 32'(rx_valid), 0);
        chk("mid_rst_din", 32'(din), 32'h100);
        chk("mid_rst_ready", 32'(req_ready), 1);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (rsp_valid) seen = 1'b1;
        end
        chk("mid_no_rsp", 32'(seen), 0);
        do_req(1'b1, 8'h42, 8'h24, lat, b1, b2, rw, rd, re, rr);
        chk("mid_after_beats", {b1, b2}, {10'h042, 10'h124});
        chk("mid_after_lat", 32'(lat), 3);
        chk("mid_after_rsp", {rw, re}, 2'b10);

        // Randomized traffic against a transaction-level schedule model.
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 256; i++) mem_m[i] = '0;
        exp_din.delete();
        exp_rsp.delete();
        free_at = 0;
        proto_from = 1 << 30;
        last_din = 10'h100;
        for (cyc = 0; cyc < 700; cyc++) begin
            @(posedge clk);
            #2;
            rdy_m     = (cyc >= free_at);
            req_valid = (cyc < 680) && ($urandom_range(0, 2) != 0);
            req_write = 1'($urandom);
            req_addr  = 8'($urandom_range(0, 15));
            req_wdata = 8'($urandom);
            if (req_valid && rdy_m) begin
                if (req_write) begin
                    exp_din[cyc+1] = {2'b00, req_addr};
                    exp_din[cyc+2] = {2'b01, req_wdata};
                    exp_rsp[cyc+3] = '{1'b1, 8'h00, 1'b0};
                    free_at = cyc + 3;
                    mem_m[req_addr] = req_wdata;
                end else begin
                    d = $urandom_range(0, TO);
                    ram_delay = d;
                    exp_din[cyc+1] = {2'b10, req_addr};
                    exp_din[cyc+2] = 10'h300;
                    if (d != 0) begin
                        exp_rsp[cyc+3+d] = '{1'b0, mem_m[req_addr], 1'b0};
                        free_at = cyc + 3 + d;
                    end else begin
                        exp_rsp[cyc+3+TO] = '{1'b0, 8'h00, 1'b1};
                        free_at = cyc + 3 + TO;
                    end
                end
            end else if (rdy_m && cyc > 300 && cyc < 680 && $urandom_range(0, 29) == 0) begin
                spur_req++;
                if (proto_from > cyc + 2) proto_from = cyc + 2;
            end
            @(negedge clk);
            chk("rnd_req_ready", 32'(req_ready), 32'(rdy_m));
            if (exp_din.exists(cyc)) begin
                chk("rnd_beat", {rx_valid, din}, {1'b1, exp_din[cyc]});
                last_din = exp_din[cyc];
                exp_din.delete(cyc);
            end else begin
                chk("rnd_hold", {rx_valid, din}, {1'b0, last_din});
            end
            if (exp_rsp.exists(cyc)) begin
                chk("rnd_rsp", {rsp_valid, rsp_write, rsp_data, rsp_err},
                    {1'b1, exp_rsp[cyc].w, exp_rsp[cyc].d, exp_rsp[cyc].e});
                exp_rsp.delete(cyc);
            end else begin
                chk("rnd_no_rsp", 32'(rsp_valid), 0);
            end
            chk("rnd_proto_err", 32'(proto_err), 32'(cyc >= proto_from));
        end
        chk("rnd_leftover", 32'(exp_din.num() + exp_rsp.num()), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
